q_perm_pipe: RTL and testbench

//  Pipelined, multi-lane Twofish q-permutation engine. Applies q0 or q1 per lane
//  to LANES bytes per beat, with 2-stage registered datapath and valid/ready

---
 rtl/twofish_pkg.sv | 36 +++
 rtl/q_perm_lane.sv | 45 ++++
 rtl/q_perm_pipe.sv | 98 +++++++++
 tb/tb_q_perm_pipe.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/twofish_pkg.sv
// Shared Twofish q-permutation constants: nibble tables t0..t3 for q0/q1,
// the lane select encoding and the nibble mixing helpers.
package twofish_pkg;

   typedef enum logic {
      QselQ0 = 1'b0,
      QselQ1 = 1'b1
   } qsel_e;

   localparam logic [3:0] Q0_T0 [16] = '{4'h8, 4'h1, 4'h7, 4'hD, 4'h6, 4'hF, 4'h3, 4'h2,
                                         4'h0, 4'hB, 4'h5, 4'h9, 4'hE, 4'hC, 4'hA, 4'h4};
   localparam logic [3:0] Q0_T1 [16] = '{4'hE, 4'hC, 4'hB, 4'h8, 4'h1, 4'h2, 4'h3, 4'h5,
                                         4'hF, 4'h4, 4'hA, 4'h6, 4'h7, 4'h0, 4'h9, 4'hD};
   localparam logic [3:0] Q0_T2 [16] = '{4'hB, 4'hA, 4'h5, 4'hE, 4'h6, 4'hD, 4'h9, 4'h0,
                                         4'hC, 4'h8, 4'hF, 4'h3, 4'h2, 4'h4, 4'h7, 4'h1};
   localparam logic [3:0] Q0_T3 [16] = '{4'hD, 4'h7, 4'hF, 4'h4, 4'h1, 4'h2, 4'h6, 4'hE,
                                         4'h9, 4'hB, 4'h3, 4'h0, 4'h8, 4'h5, 4'hC, 4'hA};
   localparam logic [3:0] Q1_T0 [16] = '{4'h2, 4'h8, 4'hB, 4'hD, 4'hF, 4'h7, 4'h6, 4'hE,
                                         4'h3, 4'h1, 4'h9, 4'h4, 4'h0, 4'hA, 4'hC, 4'h5};
   localparam logic [3:0] Q1_T1 [16] = '{4'h1, 4'hE, 4'h2, 4'hB, 4'h4, 4'hC, 4'h3, 4'h7,
                                         4'h6, 4'hD, 4'hA, 4'h5, 4'hF, 4'h9, 4'h0, 4'h8};
   localparam logic [3:0] Q1_T2 [16] = '{4'h4, 4'hC, 4'h7, 4'h5, 4'h1, 4'h6, 4'h9, 4'hA,
                                         4'h0, 4'hE, 4'hD, 4'h8, 4'h2, 4'hB, 4'h3, 4'hF};
   localparam logic [3:0] Q1_T3 [16] = '{4'hB, 4'h9, 4'h5, 4'h1, 4'hC, 4'h3, 4'hD, 4'hE,
                                         4'h6, 4'h4, 4'h7, 4'hF, 4'h2, 4'h0, 4'h8, 4'hA};

   function automatic logic [3:0] ror4_1(input logic [3:0] n);
      return {n[0], n[3:1]};
   endfunction

   // b' = a ^ ROR4(b,1) ^ (8*a mod 16)
   function automatic logic [3:0] mix_b(input logic [3:0] a, input logic [3:0] b);
      return a ^ ror4_1(b) ^ {a[0], 3'b000};
   endfunction

endpackage

// File: rtl/q_perm_lane.sv
// One byte lane of the q-permutation, split into two combinational halves so the
// parent can place a register between them.
module q_perm_lane
   import twofish_pkg::*;
(
   input  qsel_e       qsel_a_i,
   input  logic [7:0]  x_i,
   output logic [7:0]  mid_o,
   input  qsel_e       qsel_b_i,
   input  logic [7:0]  mid_i,
   output logic [7:0]  y_o
);

   logic [3:0] a1, b1, a2, b2;
   logic [3:0] a3, b3, a4, b4;

   // half_a: first mix, t0/t1; mid_o packs {a2, b2}
   always_comb begin
      a1 = x_i[7:4] ^ x_i[3:0];
      b1 = mix_b(x_i[7:4], x_i[3:0]);
      if (qsel_a_i == QselQ1) begin
         a2 = Q1_T0[a1];
         b2 = Q1_T1[b1];
      end else begin
         a2 = Q0_T0[a1];
         b2 = Q0_T1[b1];
      end
      mid_o = {a2, b2};
   end

   // half_b: second mix, t2/t3; output byte has the nibbles swapped
   always_comb begin
      a3 = mid_i[7:4] ^ mid_i[3:0];
      b3 = mix_b(mid_i[7:4], mid_i[3:0]);
      if (qsel_b_i == QselQ1) begin
         a4 = Q1_T2[a3];
         b4 = Q1_T3[b3];
      end else begin
         a4 = Q0_T2[a3];
         b4 = Q0_T3[b3];
      end
      y_o = {b4, a4};
   end

endmodule

// File: rtl/q_perm_pipe.sv
// Multi-lane Twofish q0/q1 permutation with a two-stage registered datapath and
// valid/ready handshakes on input and output, plus a completed-beat counter.
module q_perm_pipe
   import twofish_pkg::*;
#(
   parameter int unsigned LANES = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [8*LANES-1:0]   in_data,
   input  logic [LANES-1:0]     in_qsel,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*LANES-1:0]   out_data,
   output logic [CNT_W-1:0]     beat_cnt
);

   localparam int unsigned DW = 8 * LANES;

   logic              adv1, adv2, fire;
   logic              s1_valid_q, s1_valid_d;
   logic [DW-1:0]     s1_data_q, s1_data_d;
   logic [LANES-1:0]  s1_qsel_q, s1_qsel_d;
   logic              out_valid_q, out_valid_d;
   logic [DW-1:0]     out_data_q, out_data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DW-1:0]     mid_w, y_w;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      q_perm_lane u_lane (
         .qsel_a_i (qsel_e'(in_qsel[i])),
         .x_i      (in_data[8*i +: 8]),
         .mid_o    (mid_w[8*i +: 8]),
         .qsel_b_i (qsel_e'(s1_qsel_q[i])),
         .mid_i    (s1_data_q[8*i +: 8]),
         .y_o      (y_w[8*i +: 8])
      );
   end

   // Each stage moves when its downstream slot is empty or being drained.
   always_comb begin
      adv2 = ~out_valid_q | out_ready;
      adv1 = ~s1_valid_q | adv2;
      fire = out_valid_q & out_ready;
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_data_d   = s1_data_q;
      s1_qsel_d   = s1_qsel_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      cnt_d       = cnt_q;
      if (adv1) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_data_d = mid_w;
            s1_qsel_d = in_qsel;
         end
      end
      if (adv2) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_data_d = y_w;
         end
      end
      if (fire) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_qsel_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         cnt_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
         s1_qsel_q   <= s1_qsel_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         cnt_q       <= cnt_d;
      end
   end

   assign in_ready  = adv1;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_q_perm_pipe.sv
// Self-checking bench for q_perm_pipe: scoreboard of expected beats against an
// independent nibble-table model, plus handshake, reset and counter scenarios.
module tb_q_perm_pipe;

   // Tables packed as 16 nibbles, index 0 in the top nibble.
   localparam logic [63:0] M_Q0T0 = 64'h817D6F320B59ECA4;
   localparam logic [63:0] M_Q0T1 = 64'hECB81235F4A6709D;
   localparam logic [63:0] M_Q0T2 = 64'hBA5E6D90C8F32471;
   localparam logic [63:0] M_Q0T3 = 64'hD7F4126E9B3085CA;
   localparam logic [63:0] M_Q1T0 = 64'h28BDF76E31940AC5;
   localparam logic [63:0] M_Q1T1 = 64'h1E2B4C376DA5F908;
   localparam logic [63:0] M_Q1T2 = 64'h4C75169A0ED82B3F;
   localparam logic [63:0] M_Q1T3 = 64'hB951C3DE647F208A;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [3:0]  in_qsel;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [15:0] beat_cnt;
   logic        w4_in_ready;
   logic        w4_out_valid;
   logic [31:0] w4_out_data;
   logic [3:0]  w4_beat_cnt;

   int          total;
   int          bad;
   int          n_out;
   logic [31:0] exp_q[$];

   q_perm_pipe #(.LANES(4), .CNT_W(16)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_qsel   (in_qsel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .beat_cnt  (beat_cnt)
   );

   q_perm_pipe #(.LANES(4), .CNT_W(4)) u_dut_w4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (w4_in_ready),
      .in_data   (in_data),
      .in_qsel   (in_qsel),
      .out_valid (w4_out_valid),
      .out_ready (out_ready),
      .out_data  (w4_out_data),
      .beat_cnt  (w4_beat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] tnib(input logic [63:0] t, input logic [3:0] i);
      return t[63 - 4*int'(i) -: 4];
   endfunction

   function automatic logic [3:0] mixm(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] r;
      r = {b[0], b[3:1]};
      return a ^ r ^ ((a << 3) & 4'hF);
   endfunction

   function automatic logic [7:0] q_model(input logic [7:0] x, input logic s);
      logic [3:0] a1, b1, a2, b2, a3, b3, a4, b4;
      a1 = x[7:4] ^ x[3:0];
      b1 = mixm(x[7:4], x[3:0]);
      a2 = tnib(s ? M_Q1T0 : M_Q0T0, a1);
      b2 = tnib(s ? M_Q1T1 : M_Q0T1, b1);
      a3 = a2 ^ b2;
      b3 = mixm(a2, b2);
      a4 = tnib(s ? M_Q1T2 : M_Q0T2, a3);
      b4 = tnib(s ? M_Q1T3 : M_Q0T3, b3);
      return {b4, a4};
   endfunction

   function automatic logic [31:0] beat_model(input logic [31:0] d, input logic [3:0] q);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = q_model(d[8*i +: 8], q[i]);
      return r;
   endfunction

   // Drive at negedge; push the expected beat if it is accepted at the next posedge.
   task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] q,
                        input logic ordy, output logic acc);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      in_qsel   = q;
      out_ready = ordy;
      #1;
      acc = v && (in_ready === 1'b1);
      if (acc) exp_q.push_back(beat_model(d, q));
   endtask

   task automatic scoreboard_mon();
      logic [31:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            total++;
            n_out++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL sb_unexpected: got out_data=%h, required no output", out_data);
            end else begin
               e = exp_q.pop_front();
               if (out_data !== e) begin
                  bad++;
                  $display("FAIL sb_data: got %h, required %h", out_data, e);
               end
            end
         end
      end
   endtask

   task automatic drain(input string name);
      logic acc;
      int   k;
      k = 0;
      while (exp_q.size() != 0 && k < 20) begin
         drive(1'b0, 32'h0, 4'h0, 1'b1, acc);
         #2;
         k++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_drain: got %0d beats pending, required 0", name, exp_q.size());
      end
      drive(1'b0, 32'h0, 4'h0, 1'b1, acc);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      total += 3;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL rst_out_valid: got %b, required 0", out_valid);
      end
      if (beat_cnt !== 16'd0) begin
         bad++; $display("FAIL rst_beat_cnt: got %0d, required 0", beat_cnt);
      end
      if (out_data !== 32'h0) begin
         bad++; $display("FAIL rst_out_data: got %h, required 0", out_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL rst_in_ready: got %b, required 1", in_ready);
      end
   endtask

   task automatic test_known();
      logic acc;
      drive(1'b1, 32'h01000100, 4'b1010, 1'b1, acc);
      drive(1'b0, 32'h0, 4'h0, 1'b1, acc);
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL known_latency_n1: got out_valid=%b, required 0", out_valid);
      end
      drive(1'b0, 32'h0, 4'h0, 1'b1, acc);
      total += 2;
      if (out_valid !== 1'b1) begin
         bad++; $display("FAIL known_latency_n2: got out_valid=%b, required 1", out_valid);
      end
      if (out_data !== 32'hF3A9F3A9) begin
         bad++; $display("FAIL known_a: got %h, required f3a9f3a9", out_data);
      end
      drive(1'b1, 32'h00010001, 4'b1010, 1'b1, acc);
      drive(1'b0, 32'h0, 4'h0, 1'b1, acc);
      drive(1'b0, 32'h0, 4'h0, 1'b1, acc);
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'h75677567) begin
         bad++;
         $display("FAIL known_b: got v=%b %h, required v=1 75677567", out_valid, out_data);
      end
      drain("known");
   endtask

   task automatic test_exhaustive();
      logic        acc;
      logic [31:0] d;
      logic [3:0]  q;
      int          n0;
      int          nacc;
      n0   = n_out;
      nacc = 0;
      for (int k = 0; k < 128; k++) begin
         for (int i = 0; i < 4; i++) begin
            d[8*i +: 8] = 8'((4*k + i) & 255);
            q[i]        = 1'((4*k + i) >> 8);
         end
         drive(1'b1, d, q, 1'b1, acc);
         if (acc) nacc++;
      end
      drain("exh");
      total++;
      if (nacc != 128 || n_out - n0 != 128) begin
         bad++;
         $display("FAIL exh_count: got acc=%0d out=%0d, required 128/128", nacc, n_out - n0);
      end
   endtask

   task automatic test_back_to_back();
      logic acc;
      int   n0;
      int   nacc;
      apply_reset();
      n0   = n_out;
      nacc = 0;
      for (int k = 0; k < 64; k++) begin
         drive(1'b1, $urandom, 4'($urandom), 1'b1, acc);
         if (acc) nacc++;
      end
      total++;
      if (nacc != 64) begin
         bad++; $display("FAIL b2b_in_ready: got %0d accepted, required 64", nacc);
      end
      drain("b2b");
      total += 2;
      if (n_out - n0 != 64) begin
         bad++; $display("FAIL b2b_outputs: got %0d, required 64", n_out - n0);
      end
      if (beat_cnt !== 16'd64) begin
         bad++; $display("FAIL b2b_beat_cnt: got %0d, required 64", beat_cnt);
      end
   endtask

   task automatic test_backpressure();
      logic        acc;
      logic [31:0] cur;
      logic [3:0]  curq;
      logic [31:0] held;
      int          nacc;
      int          k;
      apply_reset();
      cur  = $urandom;
      curq = 4'($urandom);
      nacc = 0;
      held = '0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, cur, curq, 1'b0, acc);
         if (acc) begin
            nacc++;
            cur  = $urandom;
            curq = 4'($urandom);
         end
         if (i == 2) held = out_data;
      end
      total += 3;
      if (nacc != 2) begin
         bad++; $display("FAIL bp_accepted: got %0d, required 2", nacc);
      end
      if (in_ready !== 1'b0) begin
         bad++; $display("FAIL bp_in_ready: got %b, required 0", in_ready);
      end
      if (out_valid !== 1'b1 || out_data !== held) begin
         bad++; $display("FAIL bp_stable: got v=%b %h, required v=1 %h", out_valid, out_data, held);
      end
      k = 0;
      while (nacc < 8 && k < 40) begin
         drive(1'b1, cur, curq, 1'b1, acc);
         if (acc) begin
            nacc++;
            cur  = $urandom;
            curq = 4'($urandom);
         end
         k++;
      end
      drain("bp");
      total++;
      if (beat_cnt !== 16'd8) begin
         bad++; $display("FAIL bp_beat_cnt: got %0d, required 8", beat_cnt);
      end
   endtask

   task automatic test_reset_flight();
      logic acc;
      int   n0;
      drive(1'b1, 32'hDEADBEEF, 4'b0110, 1'b1, acc);
      drive(1'b1, 32'h12345678, 4'b1001, 1'b1, acc);
      @(negedge clk);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      #1;
      total += 2;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL rf_out_valid: got %b, required 0", out_valid);
      end
      if (beat_cnt !== 16'd0) begin
         bad++; $display("FAIL rf_beat_cnt: got %0d, required 0", beat_cnt);
      end
      exp_q.delete();
      rst_n = 1'b1;
      n0    = n_out;
      repeat (5) drive(1'b0, 32'h0, 4'h0, 1'b1, acc);
      total++;
      if (n_out != n0 || out_valid !== 1'b0) begin
         bad++; $display("FAIL rf_stale: got %0d outputs, required 0", n_out - n0);
      end
   endtask

   task automatic test_cnt_wrap();
      logic acc;
      apply_reset();
      for (int k = 0; k < 17; k++) drive(1'b1, $urandom, 4'($urandom), 1'b1, acc);
      drain("wrap");
      total += 2;
      if (w4_beat_cnt !== 4'd1) begin
         bad++; $display("FAIL wrap_cnt4: got %0d, required 1", w4_beat_cnt);
      end
      if (beat_cnt !== 16'd17) begin
         bad++; $display("FAIL wrap_cnt16: got %0d, required 17", beat_cnt);
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      n_out     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
      in_qsel   = '0;
      fork
         scoreboard_mon();
      join_none
      test_reset();
      test_known();
      test_exhaustive();
      test_back_to_back();
      test_backpressure();
      test_reset_flight();
      test_cnt_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
